warp_scheduler: RTL

// - Multi-warp control FSM for one compute core. Sequences FETCH..UPDATE for NUM_WARPS warps sharing one decode/ALU path.
// - Holds a PC and state per warp. When the active warp stalls in WAIT on its LSUs, it parks and issue switches round-robin to a ready warp.
// - Sits between dispatcher (start/done), fetcher, decoder, per-warp LSUs and per-thread PC units.

---
 rtl/warp_scheduler_pkg.sv | 22 ++
 rtl/warp_scheduler_if.sv | 34 +++
 rtl/warp_scheduler_rr_picker.sv | 28 ++
 rtl/warp_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/warp_scheduler_pkg.sv
// Shared scheduler types: per-warp core state, LSU state codes and the fetcher handshake code.
package gpu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } corestate_t;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

endpackage

// File: rtl/warp_scheduler_if.sv
// Scheduler bundle: dispatcher/fetcher/decoder/LSU/PC-unit inputs and the core-state outputs.
interface warp_scheduler_if
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_WIDTH         = 8
);
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                                             start;
  logic [NUM_WARPS-1:0]                             warp_mask;
  logic                                             decoded_ret;
  logic [2:0]                                       fetcher_state;
  logic [NUM_WARPS-1:0][THREADS_PER_WARP-1:0][1:0]  lsu_state;
  logic [THREADS_PER_WARP-1:0][PC_WIDTH-1:0]        next_pc;
  logic [PC_WIDTH-1:0]                              current_pc;
  logic [WID_W-1:0]                                 active_warp;
  corestate_t                                       core_state;
  logic [NUM_WARPS-1:0]                             warp_done;
  logic                                             done;
  logic                                             divergence_err;

  modport master (
    output start, warp_mask, decoded_ret, fetcher_state, lsu_state, next_pc,
    input  current_pc, active_warp, core_state, warp_done, done, divergence_err
  );

  modport slave (
    input  start, warp_mask, decoded_ret, fetcher_state, lsu_state, next_pc,
    output current_pc, active_warp, core_state, warp_done, done, divergence_err
  );

endinterface

// File: rtl/warp_scheduler_rr_picker.sv
// Rotate-priority picker: first ready warp strictly after cur, wrapping modulo NUM_WARPS.
module warp_rr_picker #(
  parameter  int NUM_WARPS = 2,
  localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic [NUM_WARPS-1:0] ready,
  input  logic [WID_W-1:0]     cur,
  output logic                 valid,
  output logic [WID_W-1:0]     next_id
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest ready warp is written last.
  always_comb begin
    valid   = 1'b0;
    next_id = cur;
    idx     = 0;
    for (int k = NUM_WARPS - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_WARPS;
      if (ready[WID_W'(idx)]) begin
        valid   = 1'b1;
        next_id = WID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp sequencing FSM with round-robin issue switching on LSU stalls.
// Optional feature macro: SCHED_DIVERGENCE_CHECK_EN (sticky per-thread next-PC divergence flag).
module warp_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int NUM_WARPS        = 2,
  parameter int THREADS_PER_WARP = 4,
  parameter int PC_WIDTH         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  warp_scheduler_if.slave  bus
);

  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  corestate_t           state_q  [NUM_WARPS];
  corestate_t           state_d  [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_q     [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_d     [NUM_WARPS];
  logic [WID_W-1:0]     active_q, active_d;
  logic [NUM_WARPS-1:0] warp_done_q, warp_done_d;
  logic                 done_q, done_d;
  logic                 div_err_q, div_err_d;

  logic [NUM_WARPS-1:0] lsu_clear;
  logic [NUM_WARPS-1:0] ready;
  logic                 pick_valid;
  logic [WID_W-1:0]     pick_id;
  logic                 diverged;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      lsu_clear[w] = 1'b1;
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
        if (bus.lsu_state[w][t] == LSU_REQUESTING || bus.lsu_state[w][t] == LSU_WAITING)
          lsu_clear[w] = 1'b0;
      end
      ready[w] = (WID_W'(w) != active_q) &&
                 (state_q[w] == FETCH || (state_q[w] == WAIT && lsu_clear[w]));
    end
  end

  warp_rr_picker #(.NUM_WARPS(NUM_WARPS)) u_picker (
    .ready   (ready),
    .cur     (active_q),
    .valid   (pick_valid),
    .next_id (pick_id)
  );

`ifdef SCHED_DIVERGENCE_CHECK_EN
  always_comb begin
    diverged = 1'b0;
    for (int t = 0; t < THREADS_PER_WARP; t++) begin
      if (bus.next_pc[t] != bus.next_pc[THREADS_PER_WARP-1])
        diverged = 1'b1;
    end
  end
`else
  assign diverged = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
      end
      active_q    <= '0;
      warp_done_q <= '0;
      done_q      <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      active_q    <= active_d;
      warp_done_q <= warp_done_d;
      done_q      <= done_d;
      div_err_q   <= div_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    active_d    = active_q;
    warp_done_d = warp_done_q;
    done_d      = done_q;
    div_err_d   = div_err_q;

    // Dispatcher drops start after seeing done: retire the whole block in one edge.
    if (done_q && !bus.start) begin
      for (int w = 0; w < NUM_WARPS; w++) state_d[w] = IDLE;
      warp_done_d = '0;
      done_d      = 1'b0;
      active_d    = '0;
    end else begin
      done_d = (&warp_done_q) && (state_q[active_q] != IDLE);
      case (state_q[active_q])
        IDLE: begin
          if (bus.start) begin
            active_d = '0;
            for (int w = NUM_WARPS - 1; w >= 0; w--) begin
              if (bus.warp_mask[w]) begin
                state_d[w] = FETCH;
                active_d   = WID_W'(w);
              end else begin
                state_d[w]     = DONE;
                warp_done_d[w] = 1'b1;
              end
            end
          end
        end
        FETCH: begin
          if (bus.fetcher_state == FETCHER_FETCHED) state_d[active_q] = DECODE;
        end
        DECODE:  state_d[active_q] = REQUEST;
        REQUEST: begin
          if (bus.decoded_ret) begin
            state_d[active_q]     = DONE;
            warp_done_d[active_q] = 1'b1;
            if (pick_valid) active_d = pick_id;
          end else begin
            state_d[active_q] = WAIT;
          end
        end
        WAIT: begin
          if (lsu_clear[active_q]) state_d[active_q] = EXECUTE;
          else if (pick_valid)     active_d = pick_id;
        end
        EXECUTE: state_d[active_q] = UPDATE;
        UPDATE: begin
          state_d[active_q] = FETCH;
          pc_d[active_q]    = bus.next_pc[THREADS_PER_WARP-1];
          if (diverged) div_err_d = 1'b1;
        end
        DONE: begin
          if (pick_valid) active_d = pick_id;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.core_state     = state_q[active_q];
    bus.current_pc     = pc_q[active_q];
    bus.active_warp    = active_q;
    bus.warp_done      = warp_done_q;
    bus.done           = done_q;
    bus.divergence_err = div_err_q;
  end

endmodule
